// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: 4-bit state codes, control FSM encoding and the
// successor-legality table used by the TX/RX sequencers.
package ltssm_pkg;

    localparam logic [3:0] ST_DETECT_QUIET   = 4'h0;
    localparam logic [3:0] ST_DETECT_ACTIVE  = 4'h1;
    localparam logic [3:0] ST_POLLING_ACTIVE = 4'h2;
    localparam logic [3:0] ST_POLLING_CONFIG = 4'h3;
    localparam logic [3:0] ST_CFG_LW_START   = 4'h4;
    localparam logic [3:0] ST_CFG_LW_ACCEPT  = 4'h5;
    localparam logic [3:0] ST_CFG_LN_WAIT    = 4'h6;
    localparam logic [3:0] ST_CFG_LN_ACTIVE  = 4'h7;
    localparam logic [3:0] ST_CFG_COMPLETE   = 4'h8;
    localparam logic [3:0] ST_CFG_IDLE       = 4'h9;
    localparam logic [3:0] ST_L0             = 4'hA;
    localparam logic [3:0] ST_IDLE           = 4'hF;

    // The issue step happens on the edge that leaves GAP, so it needs no state of its own.
    typedef enum logic [1:0] {
        CTRL_PARK = 2'd0,
        CTRL_GAP  = 2'd1,
        CTRL_WAIT = 2'd2
    } ctrlState_t;

    function automatic logic isLegalExit(input logic [3:0] cur, input logic [3:0] nxt);
        logic ok;
        ok = 1'b0;
        case (cur)
            ST_DETECT_QUIET:   ok = (nxt == ST_DETECT_ACTIVE);
            ST_DETECT_ACTIVE:  ok = (nxt inside {ST_DETECT_QUIET, ST_POLLING_ACTIVE});
            ST_POLLING_ACTIVE: ok = (nxt inside {ST_POLLING_CONFIG, ST_DETECT_QUIET});
            ST_POLLING_CONFIG: ok = (nxt inside {ST_CFG_LW_START, ST_DETECT_QUIET});
            ST_CFG_LW_START:   ok = (nxt inside {ST_CFG_LW_ACCEPT, ST_DETECT_QUIET});
            ST_CFG_LW_ACCEPT:  ok = (nxt inside {ST_CFG_LN_WAIT, ST_CFG_LN_ACTIVE, ST_DETECT_QUIET});
            ST_CFG_LN_WAIT:    ok = (nxt == ST_CFG_LN_ACTIVE);
            ST_CFG_LN_ACTIVE:  ok = (nxt == ST_CFG_COMPLETE);
            ST_CFG_COMPLETE:   ok = (nxt == ST_CFG_IDLE);
            ST_CFG_IDLE:       ok = (nxt inside {ST_L0, ST_DETECT_QUIET});
            ST_L0:             ok = (nxt == ST_DETECT_QUIET);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ltssm_state_timer.sv
// Saturating dwell-time counter for the current LTSSM state with expiry strobes
// for DetectQuiet and for the other timed (non-L0) training states.
module ltssm_state_timer
    import ltssm_pkg::*;
#(
    parameter int TIMEOUT_QUIET = 1200,
    parameter int TIMEOUT_STATE = 2400
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic [3:0] stateSel,
    output logic       quietExpire,
    output logic       stateExpire
);

    localparam int TIMER_MAX = (TIMEOUT_QUIET > TIMEOUT_STATE) ? TIMEOUT_QUIET : TIMEOUT_STATE;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] QUIET_LAST = TIMER_W'(TIMEOUT_QUIET - 1);
    localparam logic [TIMER_W-1:0] STATE_LAST = TIMER_W'(TIMEOUT_STATE - 1);

    logic [TIMER_W-1:0] timerCount;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            timerCount <= '0;
        end else if (clear) begin
            timerCount <= '0;
        end else if (timerCount != '1) begin
            timerCount <= timerCount + 1'b1;
        end
    end

    assign quietExpire = (stateSel == ST_DETECT_QUIET) && (timerCount == QUIET_LAST);
    assign stateExpire = (stateSel >= ST_DETECT_ACTIVE) && (stateSel <= ST_CFG_IDLE)
                         && (timerCount == STATE_LAST);

endmodule

// File: rtl/ltssm_tx_sequencer.sv
// LTSSM sequencer: issues state commands to PHY TX/RX, joins their finish
// handshakes, validates requested exits and applies per-state timeouts.
module ltssm_tx_sequencer
    import ltssm_pkg::*;
#(
    parameter int          TIMEOUT_QUIET = 1200,
    parameter int          TIMEOUT_STATE = 2400,
    parameter logic [15:0] RX_JOIN_MASK  = 16'h07FC
) (
    input  logic       pclk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       force_detect,
    input  logic       TXFinishFlag,
    input  logic [3:0] TXExitTo,
    input  logic       RXFinishFlag,
    input  logic [3:0] RXExitTo,
    output logic [3:0] SetTXState,
    output logic [3:0] SetRXState,
    output logic [3:0] ltssm_state,
    output logic       link_up,
    output logic       timeout_err,
    output logic       illegal_err
);

    ctrlState_t ctrlState;
    logic [3:0] stateReg;
    logic [3:0] targetReg;
    logic [3:0] txExitReg;
    logic [3:0] rxExitReg;
    logic       txSticky;
    logic       rxSticky;
    logic       linkUpReg;
    logic       timeoutErrReg;
    logic       illegalErrReg;

    logic       timerClear;
    logic       quietExpire;
    logic       stateExpire;
    logic       rxNeeded;
    logic       txDone;
    logic       rxDone;
    logic [3:0] txExitNow;
    logic [3:0] rxExitNow;
    logic       joinFire;
    logic       joinLegal;

    assign timerClear = (ctrlState != CTRL_WAIT);

    ltssm_state_timer #(
        .TIMEOUT_QUIET(TIMEOUT_QUIET),
        .TIMEOUT_STATE(TIMEOUT_STATE)
    ) uStateTimer (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .clear       (timerClear),
        .stateSel    (stateReg),
        .quietExpire (quietExpire),
        .stateExpire (stateExpire)
    );

    // A finish arriving this cycle completes the join without waiting for its sticky bit.
    always_comb begin
        rxNeeded  = RX_JOIN_MASK[stateReg];
        txDone    = txSticky | TXFinishFlag;
        rxDone    = rxSticky | RXFinishFlag | ~rxNeeded;
        txExitNow = txSticky ? txExitReg : TXExitTo;
        rxExitNow = rxSticky ? rxExitReg : RXExitTo;
        joinFire  = (ctrlState == CTRL_WAIT) && txDone && rxDone;
        joinLegal = isLegalExit(stateReg, txExitNow) && (!rxNeeded || (rxExitNow == txExitNow));
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            ctrlState     <= CTRL_PARK;
            stateReg      <= ST_IDLE;
            targetReg     <= ST_DETECT_QUIET;
            txExitReg     <= 4'h0;
            rxExitReg     <= 4'h0;
            txSticky      <= 1'b0;
            rxSticky      <= 1'b0;
            linkUpReg     <= 1'b0;
            timeoutErrReg <= 1'b0;
            illegalErrReg <= 1'b0;
        end else begin
            timeoutErrReg <= 1'b0;
            illegalErrReg <= 1'b0;
            if (!enable) begin
                ctrlState <= CTRL_PARK;
                stateReg  <= ST_IDLE;
                linkUpReg <= 1'b0;
                txSticky  <= 1'b0;
                rxSticky  <= 1'b0;
            end else begin
                case (ctrlState)
                    CTRL_PARK: begin
                        ctrlState <= CTRL_GAP;
                        targetReg <= ST_DETECT_QUIET;
                    end
                    CTRL_GAP: begin
                        if (force_detect) begin
                            targetReg <= ST_DETECT_QUIET;
                        end else begin
                            ctrlState <= CTRL_WAIT;
                            stateReg  <= targetReg;
                            linkUpReg <= (targetReg == ST_L0);
                            txSticky  <= 1'b0;
                            rxSticky  <= 1'b0;
                        end
                    end
                    CTRL_WAIT: begin
                        if (force_detect || joinFire || quietExpire || stateExpire) begin
                            ctrlState <= CTRL_GAP;
                            stateReg  <= ST_IDLE;
                            linkUpReg <= 1'b0;
                            if (force_detect) begin
                                targetReg <= ST_DETECT_QUIET;
                            end else if (joinFire) begin
                                targetReg     <= joinLegal ? txExitNow : ST_DETECT_QUIET;
                                illegalErrReg <= ~joinLegal;
                            end else if (quietExpire) begin
                                targetReg <= ST_DETECT_ACTIVE;
                            end else begin
                                targetReg     <= ST_DETECT_QUIET;
                                timeoutErrReg <= 1'b1;
                            end
                        end else begin
                            if (TXFinishFlag && !txSticky) begin
                                txSticky  <= 1'b1;
                                txExitReg <= TXExitTo;
                            end
                            if (RXFinishFlag && !rxSticky) begin
                                rxSticky  <= 1'b1;
                                rxExitReg <= RXExitTo;
                            end
                        end
                    end
                    default: begin
                        ctrlState <= CTRL_PARK;
                        stateReg  <= ST_IDLE;
                        linkUpReg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SetTXState  = stateReg;
    assign SetRXState  = stateReg;
    assign ltssm_state = stateReg;
    assign link_up     = linkUpReg;
    assign timeout_err = timeoutErrReg;
    assign illegal_err = illegalErrReg;

endmodule
